// File: rtl/fsm_vector_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fsm_vector_sequencer_if
// Description : Bundle of the control, vector-load, FSM-drive and result
//               signals of fsm_vector_sequencer.
//               slave  : sequencer side (drives fsm_reset/fsm_x and results)
//               master : controller side (drives start/num_vec/load_*)
//               fsm_y/fsm_state come from the FSM under control.
// Revision    : 1.0 - initial release
// ============================================================================
interface fsm_vector_sequencer_if #(
    parameter int AW = 4
);
    // Run control and vector loading
    logic          start;
    logic [AW:0]   num_vec;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;

    // Connection to the FSM under control
    logic          fsm_reset;
    logic          fsm_x;
    logic          fsm_y;
    logic [2:0]    fsm_state;

    // Status and results
    logic          busy;
    logic          done;
    logic [AW:0]   pass_count;
    logic [AW:0]   fail_count;
    logic          first_fail_valid;
    logic [AW-1:0] first_fail_idx;

    modport slave (
        input  start, num_vec, load_we, load_addr, load_data, fsm_y, fsm_state,
        output fsm_reset, fsm_x, busy, done, pass_count, fail_count,
               first_fail_valid, first_fail_idx
    );

    modport master (
        output start, num_vec, load_we, load_addr, load_data,
        input  fsm_reset, fsm_x, busy, done, pass_count, fail_count,
               first_fail_valid, first_fail_idx
    );
endinterface
`default_nettype wire

// File: rtl/fsm_vector_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fsm_vector_sequencer
// Description : Stimulus/check controller for a 3-bit-state Mealy FSM.
//               Holds DEPTH programmable vectors {x, y_exp, cstate_exp,
//               nstate_exp}, resets the FSM for two cycles, applies one x per
//               clock and scores y/state against each vector, reporting
//               pass/fail counts and the index of the first failure.
// Ports       : clk, reset (async, active-high)
//               bus (slave): start/num_vec, load_we/load_addr/load_data,
//               fsm_reset/fsm_x out, fsm_y/fsm_state in, busy, done,
//               pass_count, fail_count, first_fail_valid, first_fail_idx
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_vector_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    fsm_vector_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST1  = 3'd1,
        S_RST2  = 3'd2,
        S_RUN   = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [AW:0]   c_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] c_IDX_ONE = AW'(1);

    state_t        r_state;
    state_t        w_next;
    logic          w_busy;

    logic [7:0]    r_mem [DEPTH];

    logic [AW:0]   r_count;
    logic [AW:0]   r_passCount;
    logic [AW:0]   r_failCount;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_ffIdx;
    logic          r_ffValid;
    logic          r_fsmReset;
    logic          r_fsmX;
    logic          r_done;
    logic          r_lastPass;
    logic [2:0]    r_prevNstate;

    logic [AW:0]   w_countM1;
    logic [AW:0]   w_numSat;
    logic [AW-1:0] w_idxNext;
    logic [AW-1:0] w_xIdx;
    logic          w_lastVec;
    logic          w_vecPass;
    logic          w_revoke;
    logic          w_memWe;
    logic          w_fsmXNext;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and busy decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = S_RST1;
                end
            end
            S_RST1:  w_next = S_RST2;
            S_RST2:  w_next = (r_count == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (w_lastVec) begin
                    w_next = S_FINAL;
                end
            end
            S_FINAL: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_countM1 = r_count - c_CNT_ONE;
        w_lastVec = ({1'b0, r_idx} == w_countM1);
        w_idxNext = r_idx + c_IDX_ONE;
        w_numSat  = (bus.num_vec > c_DEPTH) ? c_DEPTH : bus.num_vec;
        w_memWe   = bus.load_we && !w_busy && ({1'b0, bus.load_addr} < c_DEPTH);

        // Vector i is scored on the cycle its x is applied; the previous
        // vector's predicted next state is confirmed here as well.
        w_vecPass = (bus.fsm_y == r_mem[r_idx][6])
                 && (bus.fsm_state == r_mem[r_idx][5:3])
                 && ((r_idx == '0) || (bus.fsm_state == r_prevNstate));

        // The last vector's next state can only be seen in FINAL, so a pass
        // already counted for it may have to be taken back.
        w_revoke  = r_lastPass && (bus.fsm_state != r_prevNstate);

        // x is registered one cycle ahead: on entry to RUN fetch vector 0,
        // during RUN fetch the following vector, hold through FINAL.
        w_xIdx     = (r_state == S_RST2) ? '0 : w_idxNext;
        w_fsmXNext = 1'b0;
        if (w_next == S_RUN) begin
            w_fsmXNext = r_mem[w_xIdx][7];
        end else if (w_next == S_FINAL) begin
            w_fsmXNext = r_fsmX;
        end
    end

    // ------------------------------------------------------------------------
    // Vector memory (not cleared by reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs, counters and scoring
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsmReset   <= 1'b1;
            r_fsmX       <= 1'b0;
            r_done       <= 1'b0;
            r_count      <= '0;
            r_passCount  <= '0;
            r_failCount  <= '0;
            r_ffValid    <= 1'b0;
            r_ffIdx      <= '0;
            r_idx        <= '0;
            r_lastPass   <= 1'b0;
            r_prevNstate <= 3'd0;
        end else begin
            r_fsmReset <= (w_next == S_RST1) || (w_next == S_RST2);
            r_fsmX     <= w_fsmXNext;
            r_done     <= (w_next == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_count     <= w_numSat;
                        r_passCount <= '0;
                        r_failCount <= '0;
                        r_ffValid   <= 1'b0;
                        r_ffIdx     <= '0;
                        r_idx       <= '0;
                        r_lastPass  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_vecPass) begin
                        r_passCount <= r_passCount + c_CNT_ONE;
                    end else begin
                        r_failCount <= r_failCount + c_CNT_ONE;
                        if (!r_ffValid) begin
                            r_ffValid <= 1'b1;
                            r_ffIdx   <= r_idx;
                        end
                    end
                    r_lastPass   <= w_vecPass;
                    r_prevNstate <= r_mem[r_idx][2:0];
                    r_idx        <= w_idxNext;
                end
                S_FINAL: begin
                    if (w_revoke) begin
                        r_passCount <= r_passCount - c_CNT_ONE;
                        r_failCount <= r_failCount + c_CNT_ONE;
                        if (!r_ffValid) begin
                            r_ffValid <= 1'b1;
                            r_ffIdx   <= w_countM1[AW-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fsm_reset        = r_fsmReset;
    assign bus.fsm_x            = r_fsmX;
    assign bus.busy             = w_busy;
    assign bus.done             = r_done;
    assign bus.pass_count       = r_passCount;
    assign bus.fail_count       = r_failCount;
    assign bus.first_fail_valid = r_ffValid;
    assign bus.first_fail_idx   = r_ffIdx;

endmodule
`default_nettype wire
